// File: rtl/radix4_mul_pkg.sv
// Shared types and helpers for the radix-4 Booth sequential multiplier.
//   state_t      : control states of the multiplier
//   booth_t      : recoded radix-4 Booth digit
//   DEF_WIDTH    : default operand width
//   booth_recode : maps {b[2i+1], b[2i], b[2i-1]} to a Booth digit
package radix4_mul_pkg;

  localparam int unsigned DEF_WIDTH = 12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    ZERO = 3'd0,
    POS1 = 3'd1,
    POS2 = 3'd2,
    NEG1 = 3'd3,
    NEG2 = 3'd4
  } booth_t;

  // Standard radix-4 Booth table; 000 and 111 both select zero.
  function automatic booth_t booth_recode(input logic [2:0] bits);
    booth_t d;
    case (bits)
      3'b001, 3'b010: d = POS1;
      3'b011:         d = POS2;
      3'b100:         d = NEG2;
      3'b101, 3'b110: d = NEG1;
      default:        d = ZERO;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/radix4_mul_seq_if.sv
// Request/result bus of the radix-4 sequential multiplier.
//   start   : request a multiply (master -> slave)
//   a, b    : signed operands, WIDTH bits (master -> slave)
//   ready   : slave can accept start (slave -> master)
//   busy    : multiply in progress (slave -> master)
//   done    : one-cycle completion pulse (slave -> master)
//   product : signed 2*WIDTH result (slave -> master)
interface radix4_mul_seq_if #(
  parameter int unsigned WIDTH = radix4_mul_pkg::DEF_WIDTH
);

  logic                 start;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 ready;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;

  modport master (
    output start, a, b,
    input  ready, busy, done, product
  );

  modport slave (
    input  start, a, b,
    output ready, busy, done, product
  );

endinterface

// File: rtl/radix4_pp_sel.sv
// Combinational partial-product selector: returns the signed multiple of a
// (0, +a, +2a, -a, -2a) chosen by one Booth digit, WIDTH+2 bits wide.
//   a     : captured multiplicand, signed
//   digit : recoded Booth digit
//   pp_c  : selected multiple, signed WIDTH+2 bits
module radix4_pp_sel
  import radix4_mul_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  booth_t           digit,
  output logic [WIDTH+1:0] pp_c
);

  localparam int unsigned MW = WIDTH + 2;

  logic [MW-1:0] a_ext;
  logic [MW-1:0] a_dbl;

  // Two guard bits make +/-2a of the most negative operand representable.
  assign a_ext = {{2{a[WIDTH-1]}}, a};
  assign a_dbl = a_ext << 1;

  always_comb begin
    pp_c = '0;
    case (digit)
      POS1:    pp_c = a_ext;
      POS2:    pp_c = a_dbl;
      NEG1:    pp_c = MW'(-a_ext);
      NEG2:    pp_c = MW'(-a_dbl);
      default: pp_c = '0;
    endcase
  end

endmodule

// File: rtl/radix4_mul_seq.sv
// Sequential signed multiplier retiring one radix-4 Booth digit per cycle.
// Fixed latency: DIGITS RUN cycles after accept, then a one-cycle DONE.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of radix4_mul_seq_if (start/a/b in,
//           ready/busy/done/product out)
module radix4_mul_seq
  import radix4_mul_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned DIGITS = WIDTH / 2
) (
  input  logic             clk,
  input  logic             rst_n,
  radix4_mul_seq_if.slave  bus
);

  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned MW    = WIDTH + 2;
  localparam int unsigned CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIGITS - 1);

  state_t           state_q;
  state_t           state_d;
  logic             ready_q, busy_q, done_q;
  logic             ready_d, busy_d, done_d;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [PW-1:0]    acc_q;
  logic [PW-1:0]    product_q;
  logic [CNT_W-1:0] cnt_q;

  logic             accept_c;
  logic             last_c;
  logic [WIDTH:0]   b_ext_c;
  logic [2:0]       bits_c;
  booth_t           digit_c;
  logic [MW-1:0]    pp_c;
  logic [PW-1:0]    pp_ext_c;
  logic [PW-1:0]    pp_sh_c;
  logic [PW-1:0]    acc_sum_c;

  assign accept_c = ready_q & bus.start;
  assign last_c   = (cnt_q == LAST_CNT);

  // Implicit b[-1] = 0 appended below the LSB; digit i reads bits 2i+1..2i-1.
  assign b_ext_c = {b_q, 1'b0};
  assign bits_c  = 3'(b_ext_c >> {cnt_q, 1'b0});
  assign digit_c = booth_recode(bits_c);

  radix4_pp_sel #(
    .WIDTH (WIDTH)
  ) u_pp_sel (
    .a     (a_q),
    .digit (digit_c),
    .pp_c  (pp_c)
  );

  // Sign-extend the multiple, weight it by 4^i, accumulate modulo 2^PW.
  assign pp_ext_c  = {{(PW - MW){pp_c[MW-1]}}, pp_c};
  assign pp_sh_c   = pp_ext_c << {cnt_q, 1'b0};
  assign acc_sum_c = acc_q + pp_sh_c;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.start) state_d = ST_RUN;
      ST_RUN:  if (last_c)    state_d = ST_DONE;
      ST_DONE: state_d = bus.start ? ST_RUN : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Status outputs are decoded from the next state and then registered.
  always_comb begin
    ready_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_d)
      ST_RUN:  busy_d = 1'b1;
      ST_DONE: begin
        ready_d = 1'b1;
        done_d  = 1'b1;
      end
      default: ready_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Datapath: capture on accept, one digit per RUN cycle, publish on last.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else if (accept_c) begin
      a_q   <= bus.a;
      b_q   <= bus.b;
      acc_q <= '0;
      cnt_q <= '0;
    end else if (state_q == ST_RUN) begin
      acc_q <= acc_sum_c;
      cnt_q <= cnt_q + CNT_W'(1);
      if (last_c) begin
        product_q <= acc_sum_c;
      end
    end
  end

  assign bus.ready   = ready_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.product = product_q;

endmodule
